tri_serial_tx: RTL and testbench

TRI_SERIAL_TX -- requirements
Module: tri_serial_tx

---
 rtl/tri_serial_tx_pkg.sv | 25 ++
 rtl/tri_serial_tx_timer.sv | 27 ++
 rtl/tri_serial_tx.sv | 132 +++++++++++++
 tb/tb_tri_serial_tx.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/tri_serial_tx_pkg.sv
// Shared definitions for the tri-state serial transmitter: state encoding and
// helpers that size the counters from the module parameters.
package tri_serial_tx_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEAD  = 3'd1,
        S_START = 3'd2,
        S_DATA  = 3'd3,
        S_STOP  = 3'd4,
        S_TURN  = 3'd5
    } tx_state_e;

    // The timer is loaded with (cycles - 1), so it must hold max(bit, turn) - 1.
    function automatic int cnt_width(input int bit_cycles, input int turn_cycles);
        int m;
        m = (bit_cycles > turn_cycles) ? bit_cycles : turn_cycles;
        return (m > 2) ? $clog2(m) : 1;
    endfunction

    function automatic int idx_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/tri_serial_tx_timer.sv
// Bit-time down-counter: reload on load_i, count toward zero, tc_o when the
// current interval has run out.
module tx_bit_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             tc_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/tri_serial_tx.sv
// Serial transmitter driving a tri-state pin: LEAD(1) START(0) DATA(LSB first)
// STOP(1), then a hi-Z turnaround. Pin data and enable come straight from flops.
//
// state | meaning
// IDLE  | pin released, waiting for a word
// LEAD  | drive 1 for one bit time
// START | drive 0 for one bit time
// DATA  | drive payload bits, LSB first
// STOP  | drive 1 for one bit time
// TURN  | pin released for the turnaround time
module tri_serial_tx
    import tri_serial_tx_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int BIT_CYCLES  = 4,
    parameter int TURN_CYCLES = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    input  logic [WIDTH-1:0] IN_DATA,
    output logic             IN_READY,
    output logic             O_DATA,
    output logic             O_CTL,
    output logic             BUSY,
    output logic             DONE
);

    localparam int CNT_W = cnt_width(BIT_CYCLES, TURN_CYCLES);
    localparam int IDX_W = idx_width(WIDTH);
    localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(BIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'((TURN_CYCLES > 0) ? TURN_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0] LAST_BIT  = IDX_W'(WIDTH - 1);

    tx_state_e        state_q;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shift_d;
    logic [IDX_W-1:0] bit_idx_q;
    logic             o_data_q;
    logic             o_ctl_q;
    logic             done_q;
    logic             ready_en_q;
    logic             tc;
    logic             last_hiz;
    logic             xfer;
    logic             timer_load;
    logic [CNT_W-1:0] load_val;

    // Ready rises on the last hi-Z cycle so a held IN_VALID starts the next
    // frame exactly when the turnaround ends, with no extra idle cycle.
    always_comb begin
        last_hiz   = tc && ((state_q == S_TURN) || (state_q == S_STOP && TURN_CYCLES == 0));
        IN_READY   = ready_en_q && ((state_q == S_IDLE) || last_hiz);
        xfer       = IN_VALID && IN_READY;
        timer_load = xfer || (state_q != S_IDLE && tc);
        load_val   = (!xfer && state_q == S_STOP) ? TURN_LOAD : BIT_LOAD;
        shift_d    = shift_q >> 1;
    end

    tx_bit_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk_i      (CLK),
        .rst_i      (RST),
        .load_i     (timer_load),
        .load_val_i (load_val),
        .tc_o       (tc)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_IDLE;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            o_data_q   <= 1'b1;
            o_ctl_q    <= 1'b1;
            done_q     <= 1'b0;
            ready_en_q <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
            done_q     <= (state_q == S_STOP) && tc;
            if (xfer) begin
                state_q   <= S_LEAD;
                shift_q   <= IN_DATA;
                bit_idx_q <= '0;
                o_data_q  <= 1'b1;
                o_ctl_q   <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: ;
                    S_LEAD: if (tc) begin
                        state_q  <= S_START;
                        o_data_q <= 1'b0;
                    end
                    S_START: if (tc) begin
                        state_q  <= S_DATA;
                        o_data_q <= shift_q[0];
                    end
                    S_DATA: if (tc) begin
                        if (bit_idx_q == LAST_BIT) begin
                            state_q  <= S_STOP;
                            o_data_q <= 1'b1;
                        end else begin
                            bit_idx_q <= bit_idx_q + 1'b1;
                            shift_q   <= shift_d;
                            o_data_q  <= shift_d[0];
                        end
                    end
                    S_STOP: if (tc) begin
                        state_q  <= (TURN_CYCLES > 0) ? S_TURN : S_IDLE;
                        o_data_q <= 1'b1;
                        o_ctl_q  <= 1'b1;
                    end
                    S_TURN: if (tc) begin
                        state_q <= S_IDLE;
                    end
                    default: begin
                        state_q  <= S_IDLE;
                        o_data_q <= 1'b1;
                        o_ctl_q  <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign O_DATA = o_data_q;
    assign O_CTL  = o_ctl_q;
    assign DONE   = done_q;
    assign BUSY   = (state_q != S_IDLE);

endmodule

// File: tb/tb_tri_serial_tx.sv
// Directed bench for tri_serial_tx: default instance plus a BIT_CYCLES=1,
// TURN_CYCLES=0 instance, table-driven frames and hand-written reset cases.
module tb_tri_serial_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       v_valid, v_ready, v_odata, v_octl, v_busy, v_done;
    logic [7:0] v_data;
    logic       f_valid, f_ready, f_odata, f_octl, f_busy, f_done;
    logic [7:0] f_data;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    tri_serial_tx #(.WIDTH(8), .BIT_CYCLES(4), .TURN_CYCLES(2)) u_dut (
        .CLK(clk), .RST(rst), .IN_VALID(v_valid), .IN_DATA(v_data),
        .IN_READY(v_ready), .O_DATA(v_odata), .O_CTL(v_octl),
        .BUSY(v_busy), .DONE(v_done)
    );

    tri_serial_tx #(.WIDTH(8), .BIT_CYCLES(1), .TURN_CYCLES(0)) u_fast (
        .CLK(clk), .RST(rst), .IN_VALID(f_valid), .IN_DATA(f_data),
        .IN_READY(f_ready), .O_DATA(f_odata), .O_CTL(f_octl),
        .BUSY(f_busy), .DONE(f_done)
    );

    typedef struct {
        logic ctl;
        logic data;
        logic ready;
        logic busy;
        logic done;
    } obs_t;

    typedef struct {
        logic [7:0] d0;
        logic [7:0] d1;
        bit         b2b;
        bit         scr;
        bit         fast;
        int         exp_rdy_edge;
        int         exp_ndone;
        int         exp_done_at;
        int         exp_hiz;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic obs_t get_obs(input bit sel);
        obs_t o;
        if (sel) begin
            o.ctl = f_octl; o.data = f_odata; o.ready = f_ready; o.busy = f_busy; o.done = f_done;
        end else begin
            o.ctl = v_octl; o.data = v_odata; o.ready = v_ready; o.busy = v_busy; o.done = v_done;
        end
        return o;
    endfunction

    task automatic set_in(input bit sel, input logic v, input logic [7:0] d);
        if (sel) begin
            f_valid = v; f_data = d;
        end else begin
            v_valid = v; v_data = d;
        end
    endtask

    // Expected {O_CTL, O_DATA} k cycles after the transfer edge (WIDTH = 8).
    function automatic logic [1:0] exp_pin(input int k, input logic [7:0] d, input int bc);
        if (k < bc)           return 2'b01;
        else if (k < 2 * bc)  return 2'b00;
        else if (k < 10 * bc) return {1'b0, d[(k - 2 * bc) / bc]};
        else if (k < 11 * bc) return 2'b01;
        else                  return 2'b11;
    endfunction

    task automatic run_frame(input bit sel, input logic [7:0] d0, input logic [7:0] d1,
                             input bit b2b, input bit scr, input int bc, input int tcy,
                             output int pre_ready, output int pin_err, output int busy_err,
                             output int rdy_edge, output int n_done, output int done_at,
                             output int hiz);
        int         flen, ncyc, kk;
        logic [7:0] cur, dexp;
        logic [1:0] e;
        logic       exp_busy;
        obs_t       o;
        flen = 11 * bc + tcy;
        ncyc = b2b ? 2 * flen + 2 : flen + 2;
        pin_err = 0; busy_err = 0; rdy_edge = -1; n_done = 0; done_at = -1; hiz = 0;
        o = get_obs(sel);
        pre_ready = int'(o.ready);
        cur = d0;
        set_in(sel, 1'b1, d0);
        @(posedge clk);
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            o = get_obs(sel);
            if (b2b && k >= flen) begin
                kk = k - flen; dexp = d1;
            end else begin
                kk = k; dexp = d0;
            end
            e = exp_pin(kk, dexp, bc);
            if ({o.ctl, o.data} !== e) pin_err++;
            exp_busy = (k < flen) || (b2b && k < 2 * flen);
            if (o.busy !== exp_busy) busy_err++;
            if (o.ready === 1'b1 && rdy_edge < 0) rdy_edge = k + 1;
            if (o.done === 1'b1) begin
                n_done++;
                if (done_at < 0) done_at = k;
            end
            if (k < flen + bc && o.ctl === 1'b1) hiz++;
            if (b2b) begin
                set_in(sel, (k < flen) ? 1'b1 : 1'b0, d1);
            end else if (scr && k < flen - 2) begin
                cur = ~cur;
                set_in(sel, 1'($urandom_range(0, 1)), cur);
            end else begin
                set_in(sel, 1'b0, cur);
            end
        end
    endtask

    initial begin
        obs_t o;
        int   pre_ready, pin_err, busy_err, rdy_edge, n_done, done_at, hiz, ctl_low;
        int   bc, tcy;

        rst = 1'b1;
        v_valid = 1'b0; v_data = 8'h00;
        f_valid = 1'b0; f_data = 8'h00;

        //          d0     d1     b2b   scr   fast  rdy  ndone done_at hiz
        vecs[0] = '{8'hA5, 8'h00, 1'b0, 1'b0, 1'b0, 46, 1, 44, 0};
        vecs[1] = '{8'h3C, 8'h00, 1'b0, 1'b1, 1'b0, 46, 1, 44, 0};
        vecs[2] = '{8'h01, 8'h00, 1'b0, 1'b1, 1'b0, 46, 1, 44, 0};
        vecs[3] = '{8'h80, 8'h00, 1'b0, 1'b0, 1'b0, 46, 1, 44, 0};
        vecs[4] = '{8'h00, 8'hFF, 1'b1, 1'b0, 1'b0, 46, 2, 44, 2};
        vecs[5] = '{8'h5A, 8'h00, 1'b0, 1'b0, 1'b1, 11, 1, 11, 0};
        vecs[6] = '{8'h81, 8'h7E, 1'b1, 1'b0, 1'b1, 11, 2, 11, 0};

        repeat (3) @(negedge clk);
        o = get_obs(1'b0);
        check("rst_ctl",   int'(o.ctl),   1);
        check("rst_data",  int'(o.data),  1);
        check("rst_ready", int'(o.ready), 0);
        check("rst_busy",  int'(o.busy),  0);
        check("rst_done",  int'(o.done),  0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst",      int'(v_ready), 1);
        check("fast_ready_after_rst", int'(f_ready), 1);

        for (int i = 0; i < 7; i++) begin
            bc  = vecs[i].fast ? 1 : 4;
            tcy = vecs[i].fast ? 0 : 2;
            run_frame(vecs[i].fast, vecs[i].d0, vecs[i].d1, vecs[i].b2b, vecs[i].scr, bc, tcy,
                      pre_ready, pin_err, busy_err, rdy_edge, n_done, done_at, hiz);
            check($sformatf("v%0d_pre_ready", i), pre_ready, 1);
            check($sformatf("v%0d_pin_errors", i), pin_err, 0);
            check($sformatf("v%0d_busy_errors", i), busy_err, 0);
            check($sformatf("v%0d_ready_edge", i), rdy_edge, vecs[i].exp_rdy_edge);
            check($sformatf("v%0d_done_count", i), n_done, vecs[i].exp_ndone);
            check($sformatf("v%0d_done_cycle", i), done_at, vecs[i].exp_done_at);
            if (vecs[i].b2b) check($sformatf("v%0d_hiz_gap", i), hiz, vecs[i].exp_hiz);
        end

        // Reset 20 cycles into a frame: pin released at that edge, frame dropped.
        set_in(1'b0, 1'b1, 8'hC3);
        @(posedge clk);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            set_in(1'b0, 1'b0, 8'h3C);
            if (k == 19) begin
                check("midrst_pre_ctl", int'(v_octl), 0);
                rst = 1'b1;
            end
        end
        @(negedge clk);
        o = get_obs(1'b0);
        check("midrst_ctl",   int'(o.ctl),   1);
        check("midrst_ready", int'(o.ready), 0);
        check("midrst_busy",  int'(o.busy),  0);
        check("midrst_done",  int'(o.done),  0);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_ready_after", int'(v_ready), 1);
        n_done = 0; ctl_low = 0;
        for (int k = 0; k < 60; k++) begin
            if (v_done === 1'b1) n_done++;
            if (v_octl !== 1'b1) ctl_low++;
            @(negedge clk);
        end
        check("midrst_no_done", n_done, 0);
        check("midrst_pin_released", ctl_low, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
